// File: rtl/gate_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// gate_sweep_ctrl
//
// Exhaustive truth-table sequencer for a 2-input combinational gate. It walks
// the gate inputs through the vectors {in1,in0} = 00, 01, 10, 11. Each vector
// is held for HOLD_CYCLES cycles, and the gate output is sampled on the last
// edge of each hold window. Every sample is compared against a 4-bit expected
// table that is latched at start. The block reports a per-vector failure mask
// and an overall pass flag.
//
// Ports:
//   clk        - single clock, rising edge
//   rst        - synchronous active-high reset
//   start      - begin a sweep (honoured only when idle)
//   expected   - expected gate output, bit i for vector i = {in1,in0}
//   dut_out    - output of the gate under check
//   in0, in1   - gate inputs, registered (bit 0 / bit 1 of the vector index)
//   busy       - high while the sweep is running
//   done       - one-cycle pulse when a sweep completes
//   pass       - last completed sweep had no mismatch (held until next start)
//   fail_mask  - bit i set if vector i mismatched (held until next start)
//   vec_idx    - current vector index, 0 outside a sweep
// -----------------------------------------------------------------------------
module gate_sweep_ctrl #(
  parameter int HOLD_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] expected,
  input  logic       dut_out,
  output logic       in0,
  output logic       in1,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask,
  output logic [1:0] vec_idx
);

  // The counter must be at least one bit wide even when HOLD_CYCLES is 1.
  localparam int            HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [1:0]    vec_q, vec_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [3:0]    exp_q, exp_d;
  logic [3:0]    fail_q, fail_d;
  logic          pass_q, pass_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  always_comb begin
    // NOTE: every signal gets a default before the case so that no path
    // leaves it unassigned; a missing default would infer a latch.
    state_d = state_q;
    vec_d   = vec_q;
    hold_d  = hold_q;
    exp_d   = exp_q;
    fail_d  = fail_q;
    pass_d  = pass_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          vec_d   = 2'd0;
          hold_d  = '0;
          exp_d   = expected;
          fail_d  = 4'b0000;
          pass_d  = 1'b0;
        end
      end
      S_RUN: begin
        if (hold_q == HOLD_LAST) begin
          // Last cycle of this vector's hold window: sample the gate here.
          hold_d         = '0;
          fail_d[vec_q]  = (dut_out != exp_q[vec_q]);
          if (vec_q == 2'd3) begin
            state_d = S_DONE;
            vec_d   = 2'd0;
            // Uses fail_d so that the vector-3 result is included.
            pass_d  = (fail_d == 4'b0000);
          end else begin
            vec_d = vec_q + 2'd1;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // busy/done are registered from the next state so they stay glitch-free.
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  // NOTE: state is updated with non-blocking assignments only; the combinational
  // block above uses blocking ones. Mixing the two styles inside one block
  // creates simulation/synthesis mismatches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      vec_q   <= 2'd0;
      hold_q  <= '0;
      exp_q   <= 4'b0000;
      fail_q  <= 4'b0000;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      hold_q  <= hold_d;
      exp_q   <= exp_d;
      fail_q  <= fail_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // vec_q is forced to 0 outside RUN, so the gate inputs idle at 00.
  assign in0       = vec_q[0];
  assign in1       = vec_q[1];
  assign vec_idx   = vec_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_mask = fail_q;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_gate_sweep_ctrl
//
// Bench for gate_sweep_ctrl. Two instances are used: dut_a has HOLD_CYCLES=2
// and dut_b has HOLD_CYCLES=1. Each instance drives a behavioural gate model.
// The stimulus pushes the expected sweep result into a per-instance queue. A
// monitor per instance records the busy window and the input-vector trace, and
// compares them with the queue head when done pulses.
// -----------------------------------------------------------------------------
module tb_gate_sweep_ctrl;

  typedef struct {
    logic        pass;
    logic [3:0]  mask;
    int          blen;
    logic [15:0] trace;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       start_a, start_b;
  logic [3:0] exp_a, exp_b;
  logic       dout_a, dout_b;
  logic       in0_a, in1_a, busy_a, done_a, pass_a;
  logic       in0_b, in1_b, busy_b, done_b, pass_b;
  logic [3:0] mask_a, mask_b;
  logic [1:0] vec_a, vec_b;
  int         mode_a;   // 0 = AND gate, 1 = output stuck at 0

  int   total = 0;
  int   bad   = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  // Gate models under check.
  assign dout_a = (mode_a == 0) ? (in0_a & in1_a) : 1'b0;
  assign dout_b = in0_b & in1_b;

  gate_sweep_ctrl #(.HOLD_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .expected(exp_a), .dut_out(dout_a),
    .in0(in0_a), .in1(in1_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .fail_mask(mask_a), .vec_idx(vec_a)
  );

  gate_sweep_ctrl #(.HOLD_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .expected(exp_b), .dut_out(dout_b),
    .in0(in0_b), .in1(in1_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .fail_mask(mask_b), .vec_idx(vec_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- monitors ----------------
  int          blen_a, blen_b;
  logic [15:0] tr_a, tr_b;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      blen_a = 0; tr_a = '0;
    end else if (busy_a) begin
      blen_a++;
      tr_a = {tr_a[13:0], in1_a, in0_a};
    end else if (done_a) begin
      if (q_a.size() == 0) begin
        check("a_unexpected_done", 1, 0);
      end else begin
        e = q_a.pop_front();
        check("a_pass", int'(pass_a), int'(e.pass));
        check("a_fail_mask", int'(mask_a), int'(e.mask));
        check("a_busy_len", blen_a, e.blen);
        check("a_vec_trace", int'(tr_a), int'(e.trace));
        check("a_done_idle_inputs", int'({in1_a, in0_a, vec_a}), 0);
      end
      blen_a = 0; tr_a = '0;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      blen_b = 0; tr_b = '0;
    end else if (busy_b) begin
      blen_b++;
      tr_b = {tr_b[13:0], in1_b, in0_b};
    end else if (done_b) begin
      if (q_b.size() == 0) begin
        check("b_unexpected_done", 1, 0);
      end else begin
        e = q_b.pop_front();
        check("b_pass", int'(pass_b), int'(e.pass));
        check("b_fail_mask", int'(mask_b), int'(e.mask));
        check("b_busy_len", blen_b, e.blen);
        check("b_vec_trace", int'(tr_b), int'(e.trace));
        check("b_done_idle_inputs", int'({in1_b, in0_b, vec_b}), 0);
      end
      blen_b = 0; tr_b = '0;
    end
  end

  // ---------------- stimulus helpers ----------------
  // Counts negedges since the start negedge (n0 already elapsed) until done.
  task automatic wait_done(input bit sel, input int n0, input int cyc, input string name);
    int n;
    n = n0;
    while (!(sel ? done_b : done_a) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({name, "_latency"}, n, cyc);
  endtask

  task automatic run_sweep(input bit sel, input logic [3:0] ev, input exp_t e,
                           input int cyc, input string name);
    if (sel) begin
      q_b.push_back(e); exp_b = ev; start_b = 1'b1;
    end else begin
      q_a.push_back(e); exp_a = ev; start_a = 1'b1;
    end
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    wait_done(sel, 1, cyc, name);
  endtask

  // Expected traces: one 2-bit {in1,in0} entry per busy cycle.
  localparam logic [15:0] TR2 = 16'b00_00_01_01_10_10_11_11;
  localparam logic [15:0] TR1 = 16'b00_01_10_11;

  initial begin
    exp_t e;
    int   n;
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
    exp_a = 4'b0000; exp_b = 4'b0000; mode_a = 0;
    repeat (2) @(negedge clk);

    // Reset with start also high: reset must win.
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check("reset_outputs_a", int'({in0_a, in1_a, busy_a, done_a, pass_a, mask_a, vec_a}), 0);
    check("reset_outputs_b", int'({in0_b, in1_b, busy_b, done_b, pass_b, mask_b, vec_b}), 0);
    rst = 1'b0;
    @(negedge clk);

    // AND gate, AND table -> pass.
    e = '{pass: 1'b1, mask: 4'b0000, blen: 8, trace: TR2};
    run_sweep(1'b0, 4'b1000, e, 9, "and_pass");
    @(negedge clk);
    check("done_one_cycle", int'(done_a), 0);
    check("idle_busy_low", int'(busy_a), 0);

    // Output stuck at 0 -> vector 3 fails; result holds afterwards.
    mode_a = 1;
    e = '{pass: 1'b0, mask: 4'b1000, blen: 8, trace: TR2};
    run_sweep(1'b0, 4'b1000, e, 9, "stuck0");
    repeat (4) @(negedge clk);
    check("stuck0_mask_held", int'(mask_a), 4'b1000);
    check("stuck0_pass_held", int'(pass_a), 0);
    mode_a = 0;

    // AND gate against an OR table -> vectors 1 and 2 fail.
    e = '{pass: 1'b0, mask: 4'b0110, blen: 8, trace: TR2};
    run_sweep(1'b0, 4'b1110, e, 9, "or_table");
    check("new_start_cleared", int'(mask_a), 4'b0110);
    @(negedge clk);

    // Mid-sweep start re-pulse and expected change: both must be ignored.
    e = '{pass: 1'b1, mask: 4'b0000, blen: 8, trace: TR2};
    q_a.push_back(e);
    exp_a = 4'b1000; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (2) @(negedge clk);
    start_a = 1'b1; exp_a = 4'b0000;
    @(negedge clk);
    start_a = 1'b0;
    wait_done(1'b0, 4, 9, "midsweep_ignore");
    // start during the DONE cycle must not be queued.
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check("start_in_done_ignored", int'(busy_a), 0);
    @(negedge clk);

    // Reset during vector 2.
    exp_a = 4'b1000; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    n = 0;
    while (vec_a != 2'd2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("reach_vector2", int'(vec_a), 2);
    rst = 1'b1;
    @(negedge clk);
    check("midsweep_reset_outputs",
          int'({in0_a, in1_a, busy_a, done_a, pass_a, mask_a, vec_a}), 0);
    rst = 1'b0;
    @(negedge clk);
    check("after_reset_idle", int'(busy_a), 0);
    e = '{pass: 1'b1, mask: 4'b0000, blen: 8, trace: TR2};
    run_sweep(1'b0, 4'b1000, e, 9, "post_reset_clean");
    @(negedge clk);

    // HOLD_CYCLES = 1 instance.
    e = '{pass: 1'b1, mask: 4'b0000, blen: 4, trace: TR1};
    run_sweep(1'b1, 4'b1000, e, 5, "hold1_and");
    @(negedge clk);
    e = '{pass: 1'b0, mask: 4'b1001, blen: 4, trace: TR1};
    run_sweep(1'b1, 4'b0001, e, 5, "hold1_bad_table");
    repeat (2) @(negedge clk);

    check("queue_a_drained", q_a.size(), 0);
    check("queue_b_drained", q_b.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gate_sweep_ctrl.md
Name: gate_sweep_ctrl

Overview:
- Sequencer that runs an exhaustive truth-table check on any 2-input combinational gate block (in0, in1 -> out), such as the AND/OR/NAND/XOR gate modules.
- Drives the gate inputs through all four vectors, holds each vector for a programmable number of cycles, and samples the gate output.
- Compares each sample against a caller-supplied 4-bit expected truth table and reports per-vector failures plus an overall pass flag.
- Sits between a top-level test/harness controller and the gate under check; replaces hand-timed stimulus sequences.

Parameters:
- HOLD_CYCLES, default 2: cycles each input vector is held before sampling; legal range is 1 or greater.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: begin a sweep; honoured only in IDLE.
- expected, input, 4: expected gate output per vector; bit i corresponds to vector i, where i = {in1,in0}; latched at start.
- dut_out, input, 1: output of the gate being checked.
- in0, output, 1: gate input 0 = bit 0 of the current vector index.
- in1, output, 1: gate input 1 = bit 1 of the current vector index.
- busy, output, 1: high while in RUN.
- done, output, 1: one-cycle pulse when a sweep completes.
- pass, output, 1: 1 when the last completed sweep had no mismatch; held until the next start.
- fail_mask, output, 4: bit i set if vector i mismatched in the last sweep; held until the next start.
- vec_idx, output, 2: current vector index; 0 outside RUN.

Behaviour:
- Reset (rst=1 at an edge), from any state including mid-sweep:
  - state = IDLE.
  - in0 = in1 = busy = done = pass = 0.
  - fail_mask = 0, vec_idx = 0, hold counter = 0.
- States and transitions:
  - IDLE -> RUN on start=1.
  - RUN -> RUN while vectors remain.
  - RUN -> DONE after vector 3 is sampled.
  - DONE -> IDLE unconditionally after 1 cycle.
- Start (edge E0, in IDLE with start=1):
  - Latch expected; clear fail_mask and pass.
  - Set vec_idx = 0, hold counter = 0, busy = 1.
  - Vector 0 (in0=0, in1=0) is visible from the cycle after E0.
- In RUN:
  - {in1,in0} = vec_idx, driven from registers (glitch-free).
  - Each edge increments the hold counter.
  - At the edge where the hold counter = HOLD_CYCLES-1: fail_mask[vec_idx] is set to (dut_out != expected_latched[vec_idx]); the hold counter resets to 0.
  - At that same edge: if vec_idx < 3, vec_idx increments; otherwise go to DONE.
- Vector order: 00, in0-only, in1-only, 11.
  - Each vector is driven for exactly HOLD_CYCLES cycles.
  - The sample is taken at the end of the last hold cycle.
- Completion:
  - After edge E0 + 4*HOLD_CYCLES: state DONE, done=1, busy=0, in0=in1=0, vec_idx=0.
  - pass = (fail_mask == 0) including the vector-3 result; valid in the same cycle done=1.
- Next edge after DONE: state IDLE, done=0; pass and fail_mask keep their values.
- start=1 while in RUN or DONE is ignored; it is not queued.
- Changes to expected during RUN have no effect.
- dut_out is sampled only at the per-vector sample edges.
- HOLD_CYCLES=1: each vector lasts one cycle; a sweep takes 4 cycles of busy.
- rst and start both high at the same edge: rst wins.

Test Plan:
- AND gate, expected=4'b1000, HOLD_CYCLES=2, pulse start at E0 -> in0/in1 step 00,10,01,11 for 2 cycles each; busy is high for 8 cycles; done pulses in cycle 9; pass=1, fail_mask=4'b0000.
- Gate output stuck at 0, expected=4'b1000 -> fail_mask=4'b1000, pass=0; both values hold after done until the next start.
- AND gate, expected=4'b1110 (OR table) -> fail_mask=4'b0110, pass=0.
- start re-pulsed mid-sweep, and expected changed to 4'b0000 mid-sweep -> sweep timing unchanged; result still pass=1 against the latched 4'b1000.
- rst asserted during vector 2 -> next cycle all outputs are 0 and state is IDLE; a subsequent start runs a full clean sweep to pass=1.
- HOLD_CYCLES=1, AND gate, expected=4'b1000 -> each vector lasts 1 cycle; done pulses 5 cycles after the start edge; pass=1.
